pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It drives the `reg_enable` and synchronous-clear inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards, taken branches, jumps, data-memory wait states and program halt. It also keeps saturating performance counters for the board display.

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/sat_counter.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared definitions for the pipeline hazard controller:
//               controller state encoding, register-file address width
//               and the hard-wired zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    // Default width of a register-file address (32 architectural registers).
    localparam int REG_ADDR_BITS = 5;

    // Register 0 is hard-wired to zero; writes to it never create a hazard.
    localparam int ZERO_REG = 0;

    // Controller state encoding.
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value instead of
//               wrapping. Cleared by synchronous reset.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk   : clock, rising edge
//   rst   : synchronous, active-high clear
//   inc   : add one this cycle (ignored once saturated)
//   count : current count value
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central stall/flush controller for the 5-stage pipeline.
//               Produces enables and synchronous clears for the PC, IF/ID,
//               ID/EX, EX/MEM and MEM/WB registers, handling data-memory
//               wait states, taken branches, load-use hazards, jumps and
//               program halt. Keeps saturating performance counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst           : clock (rising edge), synchronous active-high reset
//   id_rs/id_rs_used   : rs field of ID instruction and whether it is read
//   id_rt/id_rt_used   : rt field of ID instruction and whether it is read
//   id_jump            : unconditional jump decoded in ID
//   ex_rd              : destination register of EX instruction
//   ex_mem_read        : EX instruction is a load
//   ex_branch_taken    : branch in EX resolved taken
//   mem_busy           : data memory not ready this cycle
//   wb_halt            : halt instruction in WB
//   *_en / *_flush     : pipeline register enables / synchronous clears
//   halted             : pipeline stopped
//   cycle_cnt          : RUN cycles executed
//   load_stall_cnt     : load-use stall cycles
//   branch_flush_cnt   : taken-branch flush events
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_BITS = pipeline_pkg::REG_ADDR_BITS,
    parameter int CNT_BITS      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_ADDR_BITS-1:0] id_rs,
    input  logic                     id_rs_used,
    input  logic [REG_ADDR_BITS-1:0] id_rt,
    input  logic                     id_rt_used,
    input  logic                     id_jump,
    input  logic [REG_ADDR_BITS-1:0] ex_rd,
    input  logic                     ex_mem_read,
    input  logic                     ex_branch_taken,
    input  logic                     mem_busy,
    input  logic                     wb_halt,
    output logic                     pc_en,
    output logic                     ifid_en,
    output logic                     ifid_flush,
    output logic                     idex_en,
    output logic                     idex_flush,
    output logic                     exmem_en,
    output logic                     memwb_en,
    output logic                     halted,
    output logic [CNT_BITS-1:0]      cycle_cnt,
    output logic [CNT_BITS-1:0]      load_stall_cnt,
    output logic [CNT_BITS-1:0]      branch_flush_cnt
);

    import pipeline_pkg::*;

    state_t r_state;
    state_t w_state_next;

    logic   w_load_use;
    logic   w_inc_cycle;
    logic   w_inc_load;
    logic   w_inc_branch;

    // ------------------------------------------------------------------
    // Load-use detection. A load into register 0 produces no real value,
    // so it can never be a dependency source.
    // ------------------------------------------------------------------
    always_comb begin
        w_load_use = ex_mem_read
                  && (ex_rd != REG_ADDR_BITS'(ZERO_REG))
                  && ((id_rs_used && (id_rs == ex_rd))
                   || (id_rt_used && (id_rt == ex_rd)));
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and pipeline controls. Everything defaults to the HALT
    // behaviour (frozen, no clears, no counting); RUN overrides by
    // priority. A halt waiting on memory is deferred until the memory
    // access completes so the final store is not lost.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        idex_en      = 1'b0;
        idex_flush   = 1'b0;
        exmem_en     = 1'b0;
        memwb_en     = 1'b0;
        w_inc_cycle  = 1'b0;
        w_inc_load   = 1'b0;
        w_inc_branch = 1'b0;

        if (r_state == ST_RUN) begin
            w_inc_cycle = 1'b1;

            if (wb_halt && !mem_busy) begin
                w_state_next = ST_HALT;
            end

            if (mem_busy) begin
                // Full freeze: every register holds, nothing is cleared.
                pc_en = 1'b0;
            end else if (ex_branch_taken) begin
                // The instructions in IF and ID are on the wrong path, so
                // any hazard or jump they carry is irrelevant.
                pc_en        = 1'b1;
                ifid_en      = 1'b1;
                ifid_flush   = 1'b1;
                idex_en      = 1'b1;
                idex_flush   = 1'b1;
                exmem_en     = 1'b1;
                memwb_en     = 1'b1;
                w_inc_branch = 1'b1;
            end else if (w_load_use) begin
                // Hold PC and IF/ID, inject a bubble into ID/EX. The bubble
                // removes the load from EX next cycle, ending the stall.
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                w_inc_load = 1'b1;
            end else if (id_jump) begin
                // The sequential fetch behind the jump is discarded.
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

    // The state flop itself is the registered halt indication.
    always_comb begin
        halted = (r_state == ST_HALT);
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    sat_counter #(
        .WIDTH (CNT_BITS)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc_cycle),
        .count (cycle_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_BITS)
    ) u_load_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc_load),
        .count (load_stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_BITS)
    ) u_branch_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc_branch),
        .count (branch_flush_cnt)
    );

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl.
//               Control outputs are compared as a 7-bit vector ordered
//               {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
//                exmem_en, memwb_en}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int RA = 5;
    localparam int CW = 32;
    localparam int SW = 4;

    // Expected control vectors
    localparam logic [6:0] C_IDLE   = 7'b1101011;
    localparam logic [6:0] C_LOAD   = 7'b0001111;
    localparam logic [6:0] C_BRANCH = 7'b1111111;
    localparam logic [6:0] C_JUMP   = 7'b1111011;
    localparam logic [6:0] C_FREEZE = 7'b0000000;

    logic          clk = 1'b0;
    logic          rst;
    logic [RA-1:0] id_rs, id_rt, ex_rd;
    logic          id_rs_used, id_rt_used, id_jump;
    logic          ex_mem_read, ex_branch_taken, mem_busy, wb_halt;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic          exmem_en, memwb_en, halted;
    logic [CW-1:0] cycle_cnt, load_stall_cnt, branch_flush_cnt;

    // Saturation instance (4-bit counters), idle inputs
    logic          rst_s;
    logic          s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush;
    logic          s_exmem_en, s_memwb_en, s_halted;
    logic [SW-1:0] s_cycle_cnt, s_load_stall_cnt, s_branch_flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_BITS (RA),
        .CNT_BITS      (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs            (id_rs),
        .id_rs_used       (id_rs_used),
        .id_rt            (id_rt),
        .id_rt_used       (id_rt_used),
        .id_jump          (id_jump),
        .ex_rd            (ex_rd),
        .ex_mem_read      (ex_mem_read),
        .ex_branch_taken  (ex_branch_taken),
        .mem_busy         (mem_busy),
        .wb_halt          (wb_halt),
        .pc_en            (pc_en),
        .ifid_en          (ifid_en),
        .ifid_flush       (ifid_flush),
        .idex_en          (idex_en),
        .idex_flush       (idex_flush),
        .exmem_en         (exmem_en),
        .memwb_en         (memwb_en),
        .halted           (halted),
        .cycle_cnt        (cycle_cnt),
        .load_stall_cnt   (load_stall_cnt),
        .branch_flush_cnt (branch_flush_cnt)
    );

    pipeline_hazard_ctrl #(
        .REG_ADDR_BITS (RA),
        .CNT_BITS      (SW)
    ) dut_sat (
        .clk              (clk),
        .rst              (rst_s),
        .id_rs            ('0),
        .id_rs_used       (1'b0),
        .id_rt            ('0),
        .id_rt_used       (1'b0),
        .id_jump          (1'b0),
        .ex_rd            ('0),
        .ex_mem_read      (1'b0),
        .ex_branch_taken  (1'b0),
        .mem_busy         (1'b0),
        .wb_halt          (1'b0),
        .pc_en            (s_pc_en),
        .ifid_en          (s_ifid_en),
        .ifid_flush       (s_ifid_flush),
        .idex_en          (s_idex_en),
        .idex_flush       (s_idex_flush),
        .exmem_en         (s_exmem_en),
        .memwb_en         (s_memwb_en),
        .halted           (s_halted),
        .cycle_cnt        (s_cycle_cnt),
        .load_stall_cnt   (s_load_stall_cnt),
        .branch_flush_cnt (s_branch_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ctl();
        return {25'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rs_used = 1'b0; id_rt = '0; id_rt_used = 1'b0;
        id_jump = 1'b0; ex_rd = '0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; mem_busy = 1'b0; wb_halt = 1'b0;
    endtask

    task automatic check_cnts(input string tag, input int cyc, input int ls, input int bf);
        check({tag, ".cycle"},  cycle_cnt,        32'(cyc));
        check({tag, ".load"},   load_stall_cnt,   32'(ls));
        check({tag, ".branch"}, branch_flush_cnt, 32'(bf));
    endtask

    initial begin
        clear_inputs();
        rst   = 1'b1;
        rst_s = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("reset.halted", {31'd0, halted}, 32'd0);
        check_cnts("reset", 0, 0, 0);
        check("reset.ctl", ctl(), {25'd0, C_IDLE});

        // Load-use on rs
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_rs_used = 1'b1;
        #1 check("lu_rs.ctl", ctl(), {25'd0, C_LOAD});
        tick();
        check_cnts("lu_rs", 1, 1, 0);
        ex_mem_read = 1'b0;   // bubble now in EX
        #1 check("lu_after.ctl", ctl(), {25'd0, C_IDLE});
        tick();
        clear_inputs();

        // Register 0 never stalls
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rt = 5'd0; id_rt_used = 1'b1;
        #1 check("zero.ctl", ctl(), {25'd0, C_IDLE});
        tick();
        check("zero.load", load_stall_cnt, 32'd1);
        // Matching rt but not read: no stall
        ex_rd = 5'd9; id_rt = 5'd9; id_rt_used = 1'b0;
        #1 check("unused.ctl", ctl(), {25'd0, C_IDLE});
        tick();
        // Matching rt, read: stall
        id_rt_used = 1'b1;
        #1 check("lu_rt.ctl", ctl(), {25'd0, C_LOAD});
        tick();
        check_cnts("lu_rt", 5, 2, 0);

        // Branch overrides simultaneous load-use
        ex_branch_taken = 1'b1;
        #1 check("br_lu.ctl", ctl(), {25'd0, C_BRANCH});
        tick();
        check_cnts("br_lu", 6, 2, 1);
        clear_inputs();

        // Jump alone
        id_jump = 1'b1;
        #1 check("jump.ctl", ctl(), {25'd0, C_JUMP});
        tick();
        check_cnts("jump", 7, 2, 1);
        clear_inputs();

        // Memory wait during a branch, 3 cycles
        ex_branch_taken = 1'b1; mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("busy.ctl", ctl(), {25'd0, C_FREEZE});
            tick();
            check("busy.branch", branch_flush_cnt, 32'd1);
        end
        mem_busy = 1'b0;
        #1 check("busy_end.ctl", ctl(), {25'd0, C_BRANCH});
        tick();
        check_cnts("busy_end", 11, 2, 2);
        clear_inputs();

        // Halt blocked while memory busy
        wb_halt = 1'b1; mem_busy = 1'b1;
        tick();
        check("halt_busy.halted", {31'd0, halted}, 32'd0);
        check("halt_busy.cycle", cycle_cnt, 32'd12);

        // Reset during a load-use stall
        clear_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_rs_used = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        #1 check("rst_stall.ctl", ctl(), {25'd0, C_IDLE});
        check_cnts("rst_stall", 0, 0, 0);

        // Halt after 10 RUN cycles (the halt cycle counts)
        for (int i = 0; i < 9; i++) tick();
        wb_halt = 1'b1;
        #1 check("halt_take.ctl", ctl(), {25'd0, C_IDLE});
        tick();
        check("halt.halted", {31'd0, halted}, 32'd1);
        check("halt.cycle", cycle_cnt, 32'd10);
        check("halt.ctl", ctl(), {25'd0, C_FREEZE});
        // Nothing moves in HALT
        ex_branch_taken = 1'b1; mem_busy = 1'b0;
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_rs_used = 1'b1;
        #1 check("halt_br.ctl", ctl(), {25'd0, C_FREEZE});
        tick();
        check_cnts("halt_hold", 10, 0, 0);
        check("halt_hold.halted", {31'd0, halted}, 32'd1);

        // Reset out of HALT
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 check("unhalt.halted", {31'd0, halted}, 32'd0);
        check_cnts("unhalt", 0, 0, 0);

        // Simultaneous halt and branch
        wb_halt = 1'b1; ex_branch_taken = 1'b1;
        #1 check("halt_br2.ctl", ctl(), {25'd0, C_BRANCH});
        tick();
        check("halt_br2.halted", {31'd0, halted}, 32'd1);
        check_cnts("halt_br2", 1, 0, 1);
        clear_inputs();

        // Saturation with 4-bit counters
        rst_s = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) check("sat14.cycle", {28'd0, s_cycle_cnt}, 32'd14);
        end
        check("sat.cycle", {28'd0, s_cycle_cnt}, 32'd15);
        check("sat.halted", {31'd0, s_halted}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
